decode_stage: RTL
=================

Name: decode_stage

Overview:
- RV32I instruction decode stage; sits directly downstream of the fetch unit and consumes its 32-bit instruction word plus PC.
- Contains the 32x32 architectural register file, immediate generator and control decoder.
- Outputs are held in a single registered decode-to-execute slot under a valid/ready handshake.
- Write-back from the final stage enters through a dedicated write port.

Parameters:
- XLEN, 32, datapath and register width.
- NUM_REGS, 32, architectural register count; x0 hardwired to zero.
- RESET_PC, 32'h0000_0000, value presented on pc_o during reset.

Ports:
- clk_i  input  1  single system clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- instr_valid_i  input  1  fetch presents a valid instruction this cycle.
- instruction_i  input  32  instruction word from program memory.
- pc_i  input  32  address of instruction_i.
- instr_ready_o  output  1  stage can accept an instruction this cycle.
- flush_i  input  1  kill the held decode slot (branch redirect).
- wb_en_i  input  1  register file write enable.
- wb_rd_i  input  5  write-back destination index.
- wb_data_i  input  32  write-back data.
- dec_valid_o  output  1  decode slot holds a valid decoded instruction.
- dec_ready_i  input  1  execute accepts the slot this cycle.
- pc_o  output  32  PC of the decoded instruction.
- rs1_data_o  output  32  source operand 1.
- rs2_data_o  output  32  source operand 2.
- imm_o  output  32  sign-extended immediate.
- rd_o  output  5  destination register index.
- funct3_o  output  3  instruction funct3 field.
- funct7b5_o  output  1  instruction bit 30.
- alu_src_imm_o  output  1  ALU operand B selects imm_o.
- reg_write_o  output  1  instruction writes rd.
- mem_read_o  output  1  load.
- mem_write_o  output  1  store.
- branch_o  output  1  conditional branch.
- jump_o  output  1  JAL or JALR.
- illegal_o  output  1  unrecognised opcode.

Behaviour:
- Reset (async, immediate):
  - All registered outputs go to 0, except pc_o = RESET_PC.
  - dec_valid_o = 0 and all 31 writable registers are cleared to 0.
  - instr_ready_o reads 1 while reset is deasserted and the slot is empty.
- Handshake:
  - instr_ready_o = !dec_valid_o || dec_ready_i (combinational).
  - Accept when instr_valid_i && instr_ready_o.
  - On accept, all decode outputs are registered on the next rising edge and dec_valid_o = 1. Latency is 1 cycle.
- Slot hold: while dec_valid_o && !dec_ready_i, every output holds stable, including captured operand values.
- Slot drain: if dec_ready_i is high and there is no new accept, dec_valid_o goes to 0 on the next edge.
- Flush:
  - flush_i clears dec_valid_o on the next edge and has priority over a same-cycle accept; the accepted instruction is discarded.
  - instr_ready_o is unaffected by flush_i.
- Register file:
  - Write occurs on the rising edge when wb_en_i && wb_rd_i != 0. Writes to x0 are ignored.
  - Reads are combinational at accept time, with bypass: if wb_en_i && wb_rd_i == rs && rs != 0, the captured operand is wb_data_i.
  - rs == 0 always yields 0.
- Immediates, sign-extended from bit 31:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Opcode decode:
  - LUI 0110111: U, reg_write, alu_src_imm.
  - AUIPC 0010111: U, reg_write, alu_src_imm.
  - JAL 1101111: J, jump, reg_write.
  - JALR 1100111: I, jump, reg_write, alu_src_imm.
  - BRANCH 1100011: B, branch.
  - LOAD 0000011: I, mem_read, reg_write, alu_src_imm.
  - STORE 0100011: S, mem_write, alu_src_imm.
  - OP-IMM 0010011: I, reg_write, alu_src_imm.
  - OP 0110011: reg_write.
  - FENCE 0001111: no control bits set.
  - SYSTEM 1110011: no control bits set.
- Illegal: any other opcode, or opcode[1:0] != 2'b11, sets illegal_o = 1 and forces reg_write/mem_read/mem_write/branch/jump to 0. Valid handshake still completes.
- rd_o is forced to 0 when reg_write_o = 0.
- Reset mid-operation: the slot is discarded immediately and register contents are lost.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams;
  - typedef enum imm_sel_t {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - XLEN default;
  - packed struct ctrl_t for the control bits.
- One natural sub-module: reg_file, with 2 async read ports, 1 sync write port, async reset and x0 hardwiring.
- Bypass logic stays in decode_stage.

Test Plan:
- Reset, then accept 32'h00500093 (addi x1,x0,5) at PC 0 → next cycle: dec_valid_o=1, imm_o=5, rd_o=1, reg_write_o=1, alu_src_imm_o=1, rs1_data_o=0.
- wb_en_i=1, wb_rd_i=1, wb_data_i=32'hDEAD_BEEF in the same cycle as accepting 32'h00108133 (add x2,x1,x1) → rs1_data_o = rs2_data_o = 32'hDEADBEEF (bypass).
- Write x0 with 32'hFFFF_FFFF, then decode an instruction reading x0 → rs1_data_o=0.
- Accept 32'hFE000EE3 (beq x0,x0,-4), then hold dec_ready_i=0 for 3 cycles → imm_o=32'hFFFF_FFFC, branch_o=1, outputs stable, instr_ready_o=0; then raise dec_ready_i → slot drains.
- flush_i=1 coincident with an accept → dec_valid_o=0 next cycle; opcode 7'b1111111 → illegal_o=1 with all control bits 0.
- Assert reset_i asynchronously mid-cycle with the slot full → dec_valid_o drops before the next edge, and x1 then reads 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode values, immediate format select,
// control-bit bundle and the immediate generator used by the decode stage.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_sel_t;

    typedef struct packed {
        logic alu_src_imm;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic illegal;
    } ctrl_t;

    // Formats without an immediate (R-type, FENCE, SYSTEM, illegal) yield 0.
    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_sel_t sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear, x0 hardwired to zero.
// Ports:
//   clk_i, reset_i        clock, async active-high reset (clears all registers)
//   rs1_addr / rs1_data   read port 1
//   rs2_addr / rs2_data   read port 2
//   wr_en, wr_addr, wr_data  write port; writes to x0 are dropped
module reg_file
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
    output logic [XLEN-1:0]             rs1_data,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
    output logic [XLEN-1:0]             rs2_data,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [XLEN-1:0]             wr_data
);

    // No storage for x0; reads of index 0 are muxed to zero below.
    logic [XLEN-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file read with write-back bypass, immediate
// generation and control decode, captured into one registered slot toward
// execute under a valid/ready handshake.
// Ports:
//   clk_i, reset_i                         clock, async active-high reset
//   instr_valid_i, instruction_i, pc_i     fetch side; instr_ready_o back-pressure
//   flush_i                                drop the slot (and any same-cycle accept)
//   wb_en_i, wb_rd_i, wb_data_i            register file write-back port
//   dec_valid_o, dec_ready_i               execute side handshake
//   pc_o .. illegal_o                      registered decode results
module decode_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            instr_valid_i,
    input  logic [31:0]     instruction_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            instr_ready_o,
    input  logic            flush_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic            funct7b5_o,
    output logic            alu_src_imm_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            illegal_o
);

    logic [6:0]      opcode;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] rf_rs1;
    logic [XLEN-1:0] rf_rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_val;
    ctrl_t           ctrl;
    imm_sel_t        imm_sel;
    logic            accept;

    assign opcode  = instruction_i[6:0];
    assign rs1_idx = instruction_i[19:15];
    assign rs2_idx = instruction_i[24:20];

    reg_file #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .rs1_addr (rs1_idx),
        .rs1_data (rf_rs1),
        .rs2_addr (rs2_idx),
        .rs2_data (rf_rs2),
        .wr_en    (wb_en_i),
        .wr_addr  (wb_rd_i),
        .wr_data  (wb_data_i)
    );

    // A write landing on the same edge as the capture would otherwise be
    // missed, so forward it straight into the slot.
    assign rs1_val = (wb_en_i && wb_rd_i == rs1_idx && rs1_idx != 5'd0) ? wb_data_i : rf_rs1;
    assign rs2_val = (wb_en_i && wb_rd_i == rs2_idx && rs2_idx != 5'd0) ? wb_data_i : rf_rs2;

    // Any opcode outside the table, including those with [1:0] != 2'b11,
    // falls to the default arm with every side-effect bit clear.
    always_comb begin
        ctrl    = '0;
        imm_sel = IMM_NONE;
        case (opcode)
            OPC_LUI: begin
                imm_sel          = IMM_U;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel          = IMM_U;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
                imm_sel        = IMM_J;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_JALR: begin
                imm_sel          = IMM_I;
                ctrl.jump        = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel     = IMM_B;
                ctrl.branch = 1'b1;
            end
            OPC_LOAD: begin
                imm_sel          = IMM_I;
                ctrl.mem_read    = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                imm_sel          = IMM_S;
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_sel          = IMM_I;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

    assign imm_val       = gen_imm(instruction_i, imm_sel);
    assign instr_ready_o = !dec_valid_o || dec_ready_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dec_valid_o   <= 1'b0;
            pc_o          <= RESET_PC;
            rs1_data_o    <= '0;
            rs2_data_o    <= '0;
            imm_o         <= '0;
            rd_o          <= '0;
            funct3_o      <= '0;
            funct7b5_o    <= 1'b0;
            alu_src_imm_o <= 1'b0;
            reg_write_o   <= 1'b0;
            mem_read_o    <= 1'b0;
            mem_write_o   <= 1'b0;
            branch_o      <= 1'b0;
            jump_o        <= 1'b0;
            illegal_o     <= 1'b0;
        end else if (flush_i) begin
            // Flush wins over a same-cycle accept; the payload is left as is.
            dec_valid_o <= 1'b0;
        end else if (accept) begin
            dec_valid_o   <= 1'b1;
            pc_o          <= pc_i;
            rs1_data_o    <= rs1_val;
            rs2_data_o    <= rs2_val;
            imm_o         <= imm_val;
            rd_o          <= ctrl.reg_write ? instruction_i[11:7] : 5'd0;
            funct3_o      <= instruction_i[14:12];
            funct7b5_o    <= instruction_i[30];
            alu_src_imm_o <= ctrl.alu_src_imm;
            reg_write_o   <= ctrl.reg_write;
            mem_read_o    <= ctrl.mem_read;
            mem_write_o   <= ctrl.mem_write;
            branch_o      <= ctrl.branch;
            jump_o        <= ctrl.jump;
            illegal_o     <= ctrl.illegal;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule
